// File: rtl/snow64_iterative_shift_left_pkg.sv
// Shared types and per-size constants for the iterative shift-left unit.
// Optional rotate mode is enabled by defining SNOW64_SHIFT_LEFT_ROTATE_EN.
package snow64_iterative_shift_left_pkg;

  localparam int MSB_POS__OF_64 = 63;
  localparam int MSB_POS__OF_32 = 31;
  localparam int MSB_POS__OF_16 = 15;
  localparam int MSB_POS__OF_8  = 7;

  typedef enum logic [1:0] {
    SHL_SIZE_8  = 2'd0,
    SHL_SIZE_16 = 2'd1,
    SHL_SIZE_32 = 2'd2,
    SHL_SIZE_64 = 2'd3
  } shl_type_size_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shl_state_t;

  localparam logic [63:0] SHL_MASK_8  = 64'((65'd1 << (MSB_POS__OF_8 + 1)) - 65'd1);
  localparam logic [63:0] SHL_MASK_16 = 64'((65'd1 << (MSB_POS__OF_16 + 1)) - 65'd1);
  localparam logic [63:0] SHL_MASK_32 = 64'((65'd1 << (MSB_POS__OF_32 + 1)) - 65'd1);
  localparam logic [63:0] SHL_MASK_64 = 64'((65'd1 << (MSB_POS__OF_64 + 1)) - 65'd1);

  localparam logic [2:0] SHL_STAGES_8  = 3'($clog2(MSB_POS__OF_8 + 1));
  localparam logic [2:0] SHL_STAGES_16 = 3'($clog2(MSB_POS__OF_16 + 1));
  localparam logic [2:0] SHL_STAGES_32 = 3'($clog2(MSB_POS__OF_32 + 1));
  localparam logic [2:0] SHL_STAGES_64 = 3'($clog2(MSB_POS__OF_64 + 1));

  localparam logic [6:0] SHL_WIDTH_8  = 7'(MSB_POS__OF_8 + 1);
  localparam logic [6:0] SHL_WIDTH_16 = 7'(MSB_POS__OF_16 + 1);
  localparam logic [6:0] SHL_WIDTH_32 = 7'(MSB_POS__OF_32 + 1);
  localparam logic [6:0] SHL_WIDTH_64 = 7'(MSB_POS__OF_64 + 1);

  function automatic logic [63:0] shl_width_mask(input shl_type_size_t size);
    case (size)
      SHL_SIZE_8:  shl_width_mask = SHL_MASK_8;
      SHL_SIZE_16: shl_width_mask = SHL_MASK_16;
      SHL_SIZE_32: shl_width_mask = SHL_MASK_32;
      default:     shl_width_mask = SHL_MASK_64;
    endcase
  endfunction

  function automatic logic [2:0] shl_num_stages(input shl_type_size_t size);
    case (size)
      SHL_SIZE_8:  shl_num_stages = SHL_STAGES_8;
      SHL_SIZE_16: shl_num_stages = SHL_STAGES_16;
      SHL_SIZE_32: shl_num_stages = SHL_STAGES_32;
      default:     shl_num_stages = SHL_STAGES_64;
    endcase
  endfunction

  function automatic logic [6:0] shl_width(input shl_type_size_t size);
    case (size)
      SHL_SIZE_8:  shl_width = SHL_WIDTH_8;
      SHL_SIZE_16: shl_width = SHL_WIDTH_16;
      SHL_SIZE_32: shl_width = SHL_WIDTH_32;
      default:     shl_width = SHL_WIDTH_64;
    endcase
  endfunction

endpackage

// File: rtl/snow64_iterative_shift_left_stage.sv
// One combinational barrel stage: shifts (or rotates) by 1<<stage when the amount bit is set.
// Rotate input exists only when SNOW64_SHIFT_LEFT_ROTATE_EN is defined.
module snow64_iterative_shift_left_stage (
  input  logic [63:0] i_acc,
  input  logic [2:0]  i_stage,
  input  logic        i_amt_bit,
  input  logic [63:0] i_mask,
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
  input  logic        i_rotate,
  input  logic [6:0]  i_width,
`endif
  output logic [63:0] o_acc
);

  logic [6:0]  w_sh;
  logic [63:0] w_moved;

  assign w_sh = 7'd1 << i_stage;

`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
  // Stage shift is always narrower than the width, so width - shift never underflows.
  assign w_moved = i_rotate ? (((i_acc << w_sh) | (i_acc >> (i_width - w_sh))) & i_mask)
                            : ((i_acc << w_sh) & i_mask);
`else
  assign w_moved = (i_acc << w_sh) & i_mask;
`endif

  assign o_acc = i_amt_bit ? w_moved : i_acc;

endmodule

// File: rtl/snow64_iterative_shift_left.sv
// Multi-cycle logical shift-left (8/16/32/64-bit), one barrel stage per clock.
// Define SNOW64_SHIFT_LEFT_ROTATE_EN to add the in_rotate port and rotate-within-width mode.
module snow64_iterative_shift_left
  import snow64_iterative_shift_left_pkg::*;
#(
  parameter int WIDTH__DATA_INOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_start,
  input  logic [1:0]                   in_type_size,
  input  logic [WIDTH__DATA_INOUT-1:0] in_to_shift,
  input  logic [WIDTH__DATA_INOUT-1:0] in_amount,
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
  input  logic                         in_rotate,
`endif
  output logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH__DATA_INOUT-1:0] out_data
);

  shl_state_t  r_state;
  shl_state_t  w_next_state;
  logic [1:0]  r_size;
  logic [5:0]  r_amount;
  logic [2:0]  r_stage;
  logic [63:0] r_acc;

  logic [63:0] w_start_mask;
  logic [6:0]  w_start_width;
  logic [63:0] w_start_masked;
  logic [63:0] w_start_acc;
  logic        w_accept;
  logic        w_oversize;
  logic        w_bypass;
  logic [63:0] w_cur_mask;
  logic [2:0]  w_cur_stages;
  logic        w_last;
  logic [63:0] w_stage_acc;

  assign w_start_mask   = shl_width_mask(shl_type_size_t'(in_type_size));
  assign w_start_width  = shl_width(shl_type_size_t'(in_type_size));
  assign w_start_masked = in_to_shift & w_start_mask;
  assign w_accept       = in_start && (r_state == ST_IDLE);
  assign w_oversize     = in_amount >= {57'd0, w_start_width};

`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
  logic       r_rotate;
  logic [6:0] w_cur_width;
  assign w_bypass    = w_oversize && !in_rotate;
  assign w_cur_width = shl_width(shl_type_size_t'(r_size));
`else
  assign w_bypass = w_oversize;
`endif

  assign w_cur_mask   = shl_width_mask(shl_type_size_t'(r_size));
  assign w_cur_stages = shl_num_stages(shl_type_size_t'(r_size));
  assign w_last       = (r_stage == (w_cur_stages - 3'd1));

  // Stage 0 is applied while accepting, so the result is ready S cycles after start.
  snow64_iterative_shift_left_stage u_stage_first (
    .i_acc     (w_start_masked),
    .i_stage   (3'd0),
    .i_amt_bit (in_amount[0]),
    .i_mask    (w_start_mask),
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    .i_rotate  (in_rotate),
    .i_width   (w_start_width),
`endif
    .o_acc     (w_start_acc)
  );

  snow64_iterative_shift_left_stage u_stage_iter (
    .i_acc     (r_acc),
    .i_stage   (r_stage),
    .i_amt_bit (r_amount[r_stage]),
    .i_mask    (w_cur_mask),
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    .i_rotate  (r_rotate),
    .i_width   (w_cur_width),
`endif
    .o_acc     (w_stage_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (in_start && !w_bypass) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    out_ready = (r_state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size    <= 2'd0;
      r_amount  <= 6'd0;
      r_stage   <= 3'd0;
      r_acc     <= 64'd0;
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
      r_rotate  <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (w_accept) begin
        r_size   <= in_type_size;
        r_amount <= in_amount[5:0];
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
        r_rotate <= in_rotate;
`endif
        if (w_bypass) begin
          r_acc     <= w_start_masked;
          r_stage   <= 3'd0;
          out_data  <= '0;
          out_valid <= 1'b1;
        end else begin
          r_acc   <= w_start_acc;
          r_stage <= 3'd1;
        end
      end else if (r_state == ST_SHIFT) begin
        r_acc   <= w_stage_acc;
        r_stage <= r_stage + 3'd1;
        if (w_last) begin
          r_stage   <= 3'd0;
          out_data  <= w_stage_acc;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snow64_iterative_shift_left.sv
// Directed self-checking bench for snow64_iterative_shift_left (rotate cases when the macro is defined).
module tb_snow64_iterative_shift_left;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start;
  logic [1:0]  in_type_size;
  logic [63:0] in_to_shift;
  logic [63:0] in_amount;
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
  logic        in_rotate;
`endif
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snow64_iterative_shift_left #(.WIDTH__DATA_INOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_start     (in_start),
    .in_type_size (in_type_size),
    .in_to_shift  (in_to_shift),
    .in_amount    (in_amount),
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    .in_rotate    (in_rotate),
`endif
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble inputs after acceptance, wait (bounded) for out_valid.
  task automatic run_op(input string tag, input logic [1:0] sz, input logic [63:0] opd,
                        input logic [63:0] amt, input logic rot, input bit pulse,
                        input int exp_lat, input logic [63:0] exp_res);
    int cyc;
    int busy_rdy;
    in_start     = 1'b1;
    in_type_size = sz;
    in_to_shift  = opd;
    in_amount    = amt;
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    in_rotate    = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
    tick;
    in_start     = 1'b0;
    in_type_size = ~sz;
    in_to_shift  = 64'hA5A5_5A5A_C3C3_3C3C;
    in_amount    = 64'd3;
    cyc      = 1;
    busy_rdy = 0;
    while (!out_valid && cyc < 20) begin
      if (out_ready) busy_rdy++;
      if (pulse && cyc == 2) begin
        in_start     = 1'b1;
        in_type_size = 2'd3;
        in_to_shift  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_amount    = 64'd1;
      end
      tick;
      in_start = 1'b0;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_data"}, out_data, exp_res);
    check_eq({tag, "_ready_at_valid"}, 64'(out_ready), 64'd1);
    check_eq({tag, "_ready_while_busy"}, 64'(busy_rdy), 64'd0);
  endtask

  initial begin
    int n_late;
    rst          = 1'b1;
    in_start     = 1'b0;
    in_type_size = 2'd0;
    in_to_shift  = 64'd0;
    in_amount    = 64'd0;
`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    in_rotate    = 1'b0;
`endif
    tick;
    tick;
    rst = 1'b0;
    check_eq("reset_ready", 64'(out_ready), 64'd1);
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_data", out_data, 64'd0);

    run_op("shl64_1_by63", 2'd3, 64'h1, 64'd63, 1'b0, 1'b0, 6, 64'h8000_0000_0000_0000);
    tick;
    check_eq("valid_one_cycle", 64'(out_valid), 64'd0);
    check_eq("data_hold", out_data, 64'h8000_0000_0000_0000);

    run_op("shl8_ff81_by1", 2'd0, 64'hFFFF_FFFF_FFFF_FF81, 64'd1, 1'b0, 1'b0, 3, 64'h02);

    run_op("shl32_over32", 2'd2, 64'h0000_0000_FFFF_FFFF, 64'd32, 1'b0, 1'b0, 1, 64'd0);
    tick;
    check_eq("over_valid_one_cycle", 64'(out_valid), 64'd0);
    run_op("shl32_over2p32", 2'd2, 64'h0000_0000_FFFF_FFFF, 64'h1_0000_0000, 1'b0, 1'b0, 1, 64'd0);

    run_op("shl16_1234_by4", 2'd1, 64'h1234, 64'd4, 1'b0, 1'b1, 4, 64'h2340);
    run_op("shl8_f0_by0_b2b", 2'd0, 64'hF0, 64'd0, 1'b0, 1'b0, 3, 64'hF0);

    run_op("shl32_by31", 2'd2, 64'hFFFF_FFFF_8000_0001, 64'd31, 1'b0, 1'b0, 5, 64'h8000_0000);
    run_op("shl16_by15", 2'd1, 64'h0003, 64'd15, 1'b0, 1'b0, 4, 64'h8000);
    run_op("shl8_over8", 2'd0, 64'hFF, 64'd8, 1'b0, 1'b0, 1, 64'd0);
    run_op("shl64_by0", 2'd3, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0, 6, 64'hDEAD_BEEF_0123_4567);

    // Abort a 64-bit operation in its third SHIFT cycle.
    in_start     = 1'b1;
    in_type_size = 2'd3;
    in_to_shift  = 64'h1;
    in_amount    = 64'd5;
    tick;
    in_start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("abort_ready", 64'(out_ready), 64'd1);
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    check_eq("abort_data", out_data, 64'd0);
    n_late = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid) n_late++;
    end
    check_eq("abort_no_late_valid", 64'(n_late), 64'd0);

`ifdef SNOW64_SHIFT_LEFT_ROTATE_EN
    run_op("rot8_81_by1", 2'd0, 64'h81, 64'd1, 1'b1, 1'b0, 3, 64'h03);
    run_op("rot8_81_by9", 2'd0, 64'h81, 64'd9, 1'b1, 1'b0, 3, 64'h03);
    run_op("rot64_by65", 2'd3, 64'h8000_0000_0000_0001, 64'd65, 1'b1, 1'b0, 6, 64'h3);
    run_op("shl8_by9_norot", 2'd0, 64'h81, 64'd9, 1'b0, 1'b0, 1, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
